// File: rtl/start_text_overlay_pkg.sv
// Shared types and constants for the start-screen text overlay.
// Holds the VGA bus payload layout, blink FSM states, the prompt string
// lookup and the 8x16 glyph bitmaps used by the font ROM.
package start_text_overlay_pkg;

    localparam int unsigned HCOUNT_W     = 11;
    localparam int unsigned VCOUNT_W     = 11;
    localparam int unsigned RGB_W        = 12;
    localparam int unsigned VGA_BUS_SIZE = HCOUNT_W + VCOUNT_W + RGB_W + 4;

    localparam int unsigned CHAR_W       = 8;
    localparam int unsigned CHAR_H       = 16;
    localparam int unsigned TEXT_CHARS   = 16;
    localparam int unsigned BOX_W        = CHAR_W * TEXT_CHARS;
    localparam int unsigned BOX_H        = CHAR_H;

    localparam int unsigned ASCII_W      = 7;
    localparam int unsigned COL_W        = 3;
    localparam int unsigned ROW_W        = 4;
    localparam int unsigned DX_W         = 7;
    localparam int unsigned CHAR_IDX_W   = 4;
    localparam int unsigned ROM_ADDR_W   = ASCII_W + ROW_W;
    localparam int unsigned FONT_ROW_W   = CHAR_W;
    localparam int unsigned GLYPH_BITS   = CHAR_W * CHAR_H;

    // Bus layout, MSB first: hcount, hsync, hblnk, vcount, vsync, vblnk, rgb.
    typedef struct packed {
        logic [HCOUNT_W-1:0] hcount;
        logic                hsync;
        logic                hblnk;
        logic [VCOUNT_W-1:0] vcount;
        logic                vsync;
        logic                vblnk;
        logic [RGB_W-1:0]    rgb;
    } vga_t;

    typedef enum logic {
        SHOW = 1'b0,
        HIDE = 1'b1
    } blink_state_e;

    // Glyphs: row 0 in the top byte, bit 7 of each row is the leftmost pixel.
    localparam logic [GLYPH_BITS-1:0] GLYPH_P = 128'h0000_FCC6_C6C6_FCC0_C0C0_C0C0_0000_0000;
    localparam logic [GLYPH_BITS-1:0] GLYPH_R = 128'h0000_FCC6_C6C6_FCD8_CCC6_C6C6_0000_0000;
    localparam logic [GLYPH_BITS-1:0] GLYPH_E = 128'h0000_FEC0_C0C0_FCC0_C0C0_C0FE_0000_0000;
    localparam logic [GLYPH_BITS-1:0] GLYPH_S = 128'h0000_7CC6_C0C0_7C06_0606_C67C_0000_0000;
    localparam logic [GLYPH_BITS-1:0] GLYPH_A = 128'h0000_386C_C6C6_FEC6_C6C6_C6C6_0000_0000;
    localparam logic [GLYPH_BITS-1:0] GLYPH_C = 128'h0000_7CC6_C0C0_C0C0_C0C0_C67C_0000_0000;

    // "  PRESS  SPACE  " indexed by character position in the box.
    function automatic logic [ASCII_W-1:0] prompt_char(input logic [CHAR_IDX_W-1:0] idx);
        logic [ASCII_W-1:0] c;
        c = 7'h20;
        case (idx)
            4'd2:    c = 7'h50;
            4'd3:    c = 7'h52;
            4'd4:    c = 7'h45;
            4'd5:    c = 7'h53;
            4'd6:    c = 7'h53;
            4'd9:    c = 7'h53;
            4'd10:   c = 7'h50;
            4'd11:   c = 7'h41;
            4'd12:   c = 7'h43;
            4'd13:   c = 7'h45;
            default: c = 7'h20;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/start_text_overlay_font_rom.sv
// Synchronous 8x16 font ROM covering the characters of the start prompt.
// Ports: clk - pixel clock; addr - {ascii[6:0], row[3:0]};
//        data - glyph row, bit 7 leftmost, valid one clock after addr.
// Characters outside the prompt read as blank.
module start_text_overlay_font_rom
    import start_text_overlay_pkg::*;
(
    input  logic                  clk,
    input  logic [ROM_ADDR_W-1:0] addr,
    output logic [FONT_ROW_W-1:0] data
);

    logic [GLYPH_BITS-1:0] glyph;

    // Glyph select by ASCII code.
    always_comb begin
        glyph = '0;
        case (addr[ROM_ADDR_W-1:ROW_W])
            7'h50:   glyph = GLYPH_P;
            7'h52:   glyph = GLYPH_R;
            7'h45:   glyph = GLYPH_E;
            7'h53:   glyph = GLYPH_S;
            7'h41:   glyph = GLYPH_A;
            7'h43:   glyph = GLYPH_C;
            default: glyph = '0;
        endcase
    end

    // Row r sits at bit offset (15-r)*8; 15-r is the bitwise inverse of r.
    always_ff @(posedge clk) begin
        data <= glyph[{~addr[ROW_W-1:0], 3'b000} +: FONT_ROW_W];
    end

endmodule

// File: rtl/start_text_overlay.sv
// Start-screen text overlay: draws a blinking "PRESS  SPACE" prompt over
// the VGA pixel stream with a fixed 3-clock latency on every bus field.
// Ports: clk - pixel clock; rst - async reset, active low;
//        module_en - overlay enable (start screen shown);
//        vga_bus_in - incoming VGA bus; vga_bus_out - bus delayed 3 clocks,
//        rgb replaced by TEXT_COLOR on set glyph pixels of the text box.
module start_text_overlay
    import start_text_overlay_pkg::*;
#(
    parameter int unsigned      TEXT_X       = 256,
    parameter int unsigned      TEXT_Y       = 300,
    parameter logic [RGB_W-1:0] TEXT_COLOR   = 12'hFFF,
    parameter int unsigned      BLINK_FRAMES = 30
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    module_en,
    input  logic [VGA_BUS_SIZE-1:0] vga_bus_in,
    output logic [VGA_BUS_SIZE-1:0] vga_bus_out
);

    localparam int unsigned CNT_W = $clog2(BLINK_FRAMES) + 1;

    vga_t bus_in;
    assign bus_in = vga_t'(vga_bus_in);

    // ---------------- blink FSM ----------------
    blink_state_e     state_q, state_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             vsync_prev_q;
    logic             vsync_rise;
    logic             visible;

    assign vsync_rise = bus_in.vsync & ~vsync_prev_q;
    assign visible    = (state_q == SHOW);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= SHOW;
            frame_cnt_q  <= '0;
            vsync_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_cnt_q  <= frame_cnt_d;
            vsync_prev_q <= bus_in.vsync;
        end
    end

    // Next state: disable forces SHOW so the text appears as soon as enabled.
    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        if (!module_en) begin
            state_d     = SHOW;
            frame_cnt_d = '0;
        end else if (vsync_rise) begin
            if (frame_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
                frame_cnt_d = '0;
                state_d     = (state_q == SHOW) ? HIDE : SHOW;
            end else begin
                frame_cnt_d = frame_cnt_q + CNT_W'(1);
            end
        end
    end

    // ---------------- stage 1: box decode ----------------
    logic [DX_W-1:0]    dx;
    logic [ROW_W-1:0]   dy;
    logic               in_box;
    logic [ASCII_W-1:0] ascii;

    // Offsets truncate; explicit lower-bound compares keep wrapped values out.
    assign dx     = DX_W'(bus_in.hcount - HCOUNT_W'(TEXT_X));
    assign dy     = ROW_W'(bus_in.vcount - VCOUNT_W'(TEXT_Y));
    assign in_box = ({1'b0, bus_in.hcount} >= 12'(TEXT_X))
                 && ({1'b0, bus_in.hcount} <  12'(TEXT_X + BOX_W))
                 && ({1'b0, bus_in.vcount} >= 12'(TEXT_Y))
                 && ({1'b0, bus_in.vcount} <  12'(TEXT_Y + BOX_H));
    assign ascii  = prompt_char(dx[DX_W-1:COL_W]);

    vga_t               s1_bus;
    logic               s1_in_box;
    logic [COL_W-1:0]   s1_col;
    logic [ROW_W-1:0]   s1_row;
    logic [ASCII_W-1:0] s1_ascii;
    logic               s1_en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_bus    <= '0;
            s1_in_box <= 1'b0;
            s1_col    <= '0;
            s1_row    <= '0;
            s1_ascii  <= '0;
            s1_en     <= 1'b0;
        end else begin
            s1_bus    <= bus_in;
            s1_in_box <= in_box;
            s1_col    <= dx[COL_W-1:0];
            s1_row    <= dy;
            s1_ascii  <= ascii;
            s1_en     <= module_en & visible;
        end
    end

    // ---------------- stage 2: font lookup ----------------
    logic [FONT_ROW_W-1:0] font_row;

    start_text_overlay_font_rom u_font_rom (
        .clk  (clk),
        .addr ({s1_ascii, s1_row}),
        .data (font_row)
    );

    vga_t             s2_bus;
    logic             s2_in_box;
    logic [COL_W-1:0] s2_col;
    logic             s2_en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_bus    <= '0;
            s2_in_box <= 1'b0;
            s2_col    <= '0;
            s2_en     <= 1'b0;
        end else begin
            s2_bus    <= s1_bus;
            s2_in_box <= s1_in_box;
            s2_col    <= s1_col;
            s2_en     <= s1_en;
        end
    end

    // ---------------- stage 3: pixel select ----------------
    logic glyph_bit;
    logic draw;
    vga_t s3_bus;
    vga_t out_q;

    // Column c maps to font_row[7-c], which is the inverse of c in 3 bits.
    assign glyph_bit = font_row[~s2_col];
    assign draw      = s2_en & s2_in_box & glyph_bit & ~s2_bus.hblnk & ~s2_bus.vblnk;

    always_comb begin
        s3_bus = s2_bus;
        if (draw) begin
            s3_bus.rgb = TEXT_COLOR;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q <= '0;
        end else begin
            out_q <= s3_bus;
        end
    end

    assign vga_bus_out = out_q;

endmodule

// File: tb/tb_start_text_overlay.sv
// Self-checking bench for start_text_overlay: directed scenarios plus a
// randomized run against a behavioural pixel/blink model.
module tb_start_text_overlay;
    import start_text_overlay_pkg::*;

    localparam int          TX = 256;
    localparam int          TY = 300;
    localparam int          BF = 2;
    localparam logic [11:0] TC = 12'hFFF;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    module_en;
    logic [VGA_BUS_SIZE-1:0] vga_bus_in;
    logic [VGA_BUS_SIZE-1:0] vga_bus_out;

    int total = 0;
    int bad   = 0;

    vga_t  exp_q[$];
    int    m_edges;
    bit    m_vs_prev;
    string prompt_str = "  PRESS  SPACE  ";

    always #5 clk = ~clk;

    start_text_overlay #(
        .TEXT_X       (TX),
        .TEXT_Y       (TY),
        .TEXT_COLOR   (TC),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .module_en   (module_en),
        .vga_bus_in  (vga_bus_in),
        .vga_bus_out (vga_bus_out)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic logic [127:0] glyph_of(input byte c);
        case (c)
            "P":     return 128'h0000FCC6C6C6FCC0C0C0C0C000000000;
            "R":     return 128'h0000FCC6C6C6FCD8CCC6C6C600000000;
            "E":     return 128'h0000FEC0C0C0FCC0C0C0C0FE00000000;
            "S":     return 128'h00007CC6C0C07C060606C67C00000000;
            "A":     return 128'h0000386CC6C6FEC6C6C6C6C600000000;
            "C":     return 128'h00007CC6C0C0C0C0C0C0C67C00000000;
            default: return 128'h0;
        endcase
    endfunction

    function automatic vga_t model_px(input vga_t px, input bit on);
        vga_t        r;
        int          x, y, dx, dy;
        logic [7:0]  rowbyte;
        r  = px;
        x  = int'(px.hcount);
        y  = int'(px.vcount);
        dx = x - TX;
        dy = y - TY;
        if (on && !px.hblnk && !px.vblnk &&
            x >= TX && x < TX + 128 && y >= TY && y < TY + 16) begin
            rowbyte = 8'(glyph_of(prompt_str[dx / 8]) >> (8 * (15 - dy)));
            if (rowbyte[7 - (dx % 8)]) r.rgb = TC;
        end
        return r;
    endfunction

    function automatic vga_t mk(input int h, input int v, input logic [11:0] rgb,
                                input bit hs, input bit hb, input bit vs, input bit vb);
        vga_t p;
        p.hcount = 11'(h);
        p.hsync  = hs;
        p.hblnk  = hb;
        p.vcount = 11'(v);
        p.vsync  = vs;
        p.vblnk  = vb;
        p.rgb    = rgb;
        return p;
    endfunction

    // One pixel clock: sample the output due now, drive the next pixel.
    task automatic step(input vga_t px, input bit en, output vga_t got, output vga_t exp);
        bit vis;
        @(negedge clk);
        got        = vga_t'(vga_bus_out);
        exp        = exp_q.pop_front();
        vga_bus_in = px;
        module_en  = en;
        vis        = ((m_edges / BF) % 2) == 0;
        exp_q.push_back(model_px(px, en && vis));
        if (!en) m_edges = 0;
        else if (px.vsync && !m_vs_prev) m_edges++;
        m_vs_prev = px.vsync;
    endtask

    // Drive a pixel then idle; returns the output that carries that pixel.
    task automatic run_px(input vga_t px, input bit en, output vga_t got, output vga_t exp);
        vga_t g, e, idle;
        idle = mk(0, 0, 12'h000, 0, 0, px.vsync, 0);
        step(px, en, g, e);
        for (int i = 0; i < 3; i++) step(idle, en, got, exp);
    endtask

    task automatic vpulse(input bit en);
        vga_t g, e;
        step(mk(0, 600, 12'h000, 0, 1, 1, 1), en, g, e);
        step(mk(0, 601, 12'h000, 0, 1, 0, 1), en, g, e);
    endtask

    task automatic assert_reset();
        rst        = 1'b0;
        module_en  = 1'b0;
        vga_bus_in = '0;
        exp_q      = {vga_t'(0), vga_t'(0), vga_t'(0)};
        m_edges    = 0;
        m_vs_prev  = 0;
    endtask

    task automatic reset_cycle();
        @(negedge clk);
        assert_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        vga_t got, exp;
        rst = 1'b1;
        #2;
        assert_reset();
        #1;
        total++;
        if (vga_bus_out !== '0) begin
            bad++; $display("FAIL reset_initial got=%h exp=0", vga_bus_out);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(mk(i + 5, 40, 12'($urandom) | 12'h001, 1, 0, 0, 0), 0, got, exp);
            if (i < 3) begin
                total++;
                if (got !== vga_t'(0)) begin
                    bad++; $display("FAIL reset_refill%0d got=%h exp=0", i, got);
                end
            end
            total++;
            if (got !== exp) begin
                bad++; $display("FAIL reset_stream%0d got=%h exp=%h", i, got, exp);
            end
        end
        // Asynchronous assertion mid-line must clear the output with no clock edge.
        #2;
        assert_reset();
        #1;
        total++;
        if (vga_bus_out !== '0) begin
            bad++; $display("FAIL reset_async got=%h exp=0", vga_bus_out);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(mk(i + 100, 41, 12'h5A5, 0, 0, 0, 0), 0, got, exp);
            total++;
            if (got !== exp) begin
                bad++; $display("FAIL reset_resume%0d got=%h exp=%h", i, got, exp);
            end
        end
    endtask

    task automatic test_passthrough();
        vga_t px, got, exp;
        px = mk(10, 20, 12'h123, 1, 0, 0, 0);
        run_px(px, 0, got, exp);
        total++;
        if (got !== px) begin
            bad++; $display("FAIL passthrough got=%h exp=%h", got, px);
        end
        total++;
        if (got !== exp) begin
            bad++; $display("FAIL passthrough_model got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_glyph();
        vga_t got, exp;
        reset_cycle();
        run_px(mk(TX + 16, TY + 2, 12'h0A0, 0, 0, 0, 0), 1, got, exp);
        total++;
        if (got.rgb !== 12'hFFF || got !== exp) begin
            bad++; $display("FAIL glyph_hit got=%h exp_rgb=fff exp=%h", got, exp);
        end
        run_px(mk(TX + 22, TY + 2, 12'h0A0, 0, 0, 0, 0), 1, got, exp);
        total++;
        if (got.rgb !== 12'h0A0 || got !== exp) begin
            bad++; $display("FAIL glyph_clear got=%h exp_rgb=0a0 exp=%h", got, exp);
        end
    endtask

    task automatic test_bounds();
        vga_t got, exp;
        int   hs[6];
        int   vs[6];
        bit   hb[6];
        hs = '{TX - 1, TX + 128, TX + 16, TX - 112, TX + 144, TX + 16};
        vs = '{TY + 2, TY + 2,   TY + 2,  TY + 2,   TY + 2,   TY - 14};
        hb = '{0,      0,        1,       0,        0,        0};
        for (int i = 0; i < 6; i++) begin
            run_px(mk(hs[i], vs[i], 12'h3C5, 0, hb[i], 0, 0), 1, got, exp);
            total++;
            if (got.rgb !== 12'h3C5 || got !== exp) begin
                bad++; $display("FAIL bounds%0d got=%h exp_rgb=3c5 exp=%h", i, got, exp);
            end
        end
    endtask

    task automatic test_blink();
        vga_t        px, got, exp;
        logic [11:0] want[5];
        want = '{12'hFFF, 12'hFFF, 12'h0A0, 12'h0A0, 12'hFFF};
        reset_cycle();
        px = mk(TX + 16, TY + 5, 12'h0A0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) vpulse(1);
            run_px(px, 1, got, exp);
            total++;
            if (got.rgb !== want[k] || got !== exp) begin
                bad++; $display("FAIL blink_edges%0d got=%h exp_rgb=%h exp=%h", k, got, want[k], exp);
            end
        end
    endtask

    task automatic test_disable();
        vga_t px, got, exp;
        reset_cycle();
        px = mk(TX + 80, TY + 3, 12'h0A0, 0, 0, 0, 0);
        repeat (3) vpulse(1);
        run_px(px, 1, got, exp);
        total++;
        if (got.rgb !== 12'h0A0 || got !== exp) begin
            bad++; $display("FAIL disable_hidden got=%h exp_rgb=0a0 exp=%h", got, exp);
        end
        // vsync rises in the single disabled cycle; the disable must win.
        step(mk(0, 600, 12'h000, 0, 1, 1, 1), 0, got, exp);
        run_px(mk(TX + 80, TY + 3, 12'h0A0, 0, 0, 1, 0), 1, got, exp);
        total++;
        if (got.rgb !== 12'hFFF || got !== exp) begin
            bad++; $display("FAIL disable_reenable got=%h exp_rgb=fff exp=%h", got, exp);
        end
        step(mk(0, 601, 12'h000, 0, 1, 0, 1), 1, got, exp);
        vpulse(1);
        run_px(px, 1, got, exp);
        total++;
        if (got.rgb !== 12'hFFF || got !== exp) begin
            bad++; $display("FAIL disable_cnt_cleared got=%h exp_rgb=fff exp=%h", got, exp);
        end
        vpulse(1);
        run_px(px, 1, got, exp);
        total++;
        if (got.rgb !== 12'h0A0 || got !== exp) begin
            bad++; $display("FAIL disable_rehide got=%h exp_rgb=0a0 exp=%h", got, exp);
        end
    endtask

    task automatic test_random();
        vga_t got, exp;
        bit   vs_state;
        int   errs;
        vs_state = 0;
        errs     = 0;
        reset_cycle();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(9, 0) == 0) vs_state = ~vs_state;
            step(mk(int'($urandom_range(TX + 150, TX - 130)),
                    int'($urandom_range(TY + 20, TY - 16)),
                    12'($urandom),
                    1'($urandom),
                    $urandom_range(15, 0) == 0,
                    vs_state,
                    $urandom_range(31, 0) == 0),
                 $urandom_range(19, 0) != 0, got, exp);
            total++;
            if (got !== exp) begin
                bad++;
                if (errs < 10) $display("FAIL random%0d got=%h exp=%h", i, got, exp);
                errs++;
            end
        end
    endtask

    task automatic test_back_to_back();
        vga_t got, exp;
        for (int i = 0; i < 140; i++) begin
            step(mk(TX - 6 + i, TY + 7, 12'h246, 0, 0, 0, 0), 1, got, exp);
            total++;
            if (got !== exp) begin
                bad++; $display("FAIL back_to_back%0d got=%h exp=%h", i, got, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_glyph();
        test_bounds();
        test_blink();
        test_disable();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
